// File: rtl/irq_collector_if.sv
// AXI-Lite bus bundle for the interrupt collector register port.
//   slave  modport : used by irq_collector (accepts AW/W/AR, returns B/R)
//   master modport : used by the bus side (drives AW/W/AR, accepts B/R)
interface irq_collector_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/irq_collector.sv
// Interrupt collector: gathers NUM_SOURCES peripheral interrupt lines, keeps a
// pending view with per-source edge/level triggering and enable, and drives one
// registered interrupt line to the core. Software claims the lowest pending and
// enabled source through the CLAIM register.
//
// Ports:
//   clock_i    system clock
//   reset_ni   synchronous active-low reset
//   irq_src_i  interrupt sources, bit k is source ID k+1
//   irq_o      registered interrupt to core
//   s_axilite  AXI-Lite slave (irq_collector_if.slave)
//
// Register map (addr[3:2]): 0 PENDING (ro), 1 ENABLE (rw), 2 CLAIM (ro, read
// clears the returned edge source), 3 TRIGGER (rw, 1 = edge, 0 = level).
//
// Build option: define IRQ_COLLECTOR_SYNC_EN to pass irq_src_i through a
// 2-flop synchronizer (source-to-irq_o latency 4 cycles instead of 2).
module irq_collector #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  output logic                   irq_o,
  irq_collector_if.slave         s_axilite
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  localparam logic [1:0] SEL_PENDING = 2'd0;
  localparam logic [1:0] SEL_ENABLE  = 2'd1;
  localparam logic [1:0] SEL_CLAIM   = 2'd2;
  localparam logic [1:0] SEL_TRIGGER = 2'd3;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  logic [NUM_SOURCES-1:0] src_p0, hist, pend_p1, pend_nxt, rise;
  logic [NUM_SOURCES-1:0] enable, trigger, claim_clr;
  logic                   irq_p2;

  wstate_t               wstate;
  logic                  awready_q, wready_q, bvalid_q, aw_got, w_got;
  logic [1:0]            aw_sel_q, wr_sel;
  logic [31:0]           wdata_q, wr_data, en_wr, trig_wr;
  logic [3:0]            wstrb_q, wr_strb;
  logic                  aw_fire, w_fire, wr_fire;

  rstate_t               rstate;
  logic                  arready_q, rvalid_q, claim_rd_q;
  logic [4:0]            claim_id, claim_id_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_word;
  logic                  ar_fire, r_fire;

  // ---- source capture stage (p0) ----
`ifdef IRQ_COLLECTOR_SYNC_EN
  logic [NUM_SOURCES-1:0] sync_a, sync_b;
  always_ff @(posedge clock_i) begin
    sync_a <= irq_src_i;
    sync_b <= sync_a;
  end
  assign src_p0 = sync_b;
`else
  assign src_p0 = irq_src_i;
`endif

  // ---- pending stage (p1) ----
  assign rise = src_p0 & ~hist;
  // Edge bits: a new rising edge beats a claim in the same cycle.
  // Level bits: track the source, claims are ignored.
  assign pend_nxt = (trigger & ((pend_p1 & ~claim_clr) | rise)) | (~trigger & src_p0);

  always_comb begin
    claim_clr = '0;
    if (r_fire && claim_rd_q)
      for (int k = 0; k < NUM_SOURCES; k++)
        if (claim_id_q == 5'(k + 1)) claim_clr[k] = 1'b1;
  end

  always_comb begin
    claim_id = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--)
      if (pend_p1[k] && enable[k]) claim_id = 5'(k + 1);
  end

  assign en_wr   = apply_strb(32'(enable),  wr_data, wr_strb);
  assign trig_wr = apply_strb(32'(trigger), wr_data, wr_strb);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      enable  <= '0;
      trigger <= '0;
      pend_p1 <= '0;
      hist    <= '0;
      irq_p2  <= 1'b0;
    end else begin
      if (wr_fire && wr_sel == SEL_ENABLE)  enable  <= en_wr[NUM_SOURCES-1:0];
      if (wr_fire && wr_sel == SEL_TRIGGER) trigger <= trig_wr[NUM_SOURCES-1:0];
      hist    <= src_p0;
      pend_p1 <= pend_nxt;
      // ---- output stage (p2) ----
      irq_p2  <= |(pend_p1 & enable);
    end
  end

  assign irq_o = irq_p2;

  // Write path: AW and W are captured independently; the write fires on the
  // cycle the second of the two arrives (or both together).
  assign aw_fire = s_axilite.awvalid && awready_q;
  assign w_fire  = s_axilite.wvalid  && wready_q;
  assign wr_sel  = aw_got ? aw_sel_q : s_axilite.awaddr[3:2];
  assign wr_data = w_got  ? wdata_q  : s_axilite.wdata;
  assign wr_strb = w_got  ? wstrb_q  : s_axilite.wstrb;
  assign wr_fire = (wstate == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);

  always_ff @(posedge clock_i) begin
    if (aw_fire) aw_sel_q <= s_axilite.awaddr[3:2];
    if (w_fire) begin
      wdata_q <= s_axilite.wdata;
      wstrb_q <= s_axilite.wstrb;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (wr_fire) begin
            wstate    <= W_RESP;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
          end else begin
            if (aw_fire) aw_got <= 1'b1;
            if (w_fire)  w_got  <= 1'b1;
            awready_q <= !(aw_got || aw_fire);
            wready_q  <= !(w_got  || w_fire);
          end
        end
        W_RESP: begin
          if (s_axilite.bready) begin
            wstate    <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: data is latched at the AR handshake and held until accepted.
  assign ar_fire = s_axilite.arvalid && arready_q;
  assign r_fire  = rvalid_q && s_axilite.rready;

  always_comb begin
    rd_word = '0;
    case (s_axilite.araddr[3:2])
      SEL_PENDING: rd_word[NUM_SOURCES-1:0] = pend_p1;
      SEL_ENABLE:  rd_word[NUM_SOURCES-1:0] = enable;
      SEL_CLAIM:   rd_word[4:0]             = claim_id;
      SEL_TRIGGER: rd_word[NUM_SOURCES-1:0] = trigger;
      default:     rd_word                  = '0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (ar_fire) begin
      rdata_q    <= rd_word;
      claim_id_q <= claim_id;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      rstate     <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      claim_rd_q <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_fire) begin
            rstate     <= R_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            claim_rd_q <= (s_axilite.araddr[3:2] == SEL_CLAIM);
          end
        end
        R_DATA: begin
          if (s_axilite.rready) begin
            rstate     <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            claim_rd_q <= 1'b0;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axilite.awready = awready_q;
  assign s_axilite.wready  = wready_q;
  assign s_axilite.bvalid  = bvalid_q;
  assign s_axilite.bresp   = 2'b00;
  assign s_axilite.arready = arready_q;
  assign s_axilite.rvalid  = rvalid_q;
  assign s_axilite.rdata   = rdata_q;
  assign s_axilite.rresp   = 2'b00;

endmodule

// File: tb/tb_irq_collector.sv
module tb_irq_collector;
  localparam logic [31:0] A_PEND = 32'h0, A_EN = 32'h4, A_CLAIM = 32'h8, A_TRIG = 32'hC;

  logic       clk, rst_n, irq;
  logic [2:0] irq_src;
  int         tests, fails;

  irq_collector_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  irq_collector #(.NUM_SOURCES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .irq_src_i(irq_src),
    .irq_o    (irq),
    .s_axilite(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_hs, w_hs, hs;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0; resp = 2'b11;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      step();
      if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin axi.wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi.bvalid;
      if (hs) resp = axi.bresp;
      step();
      n++;
    end
    axi.bready = 1'b0;
    if (!aw_done || !w_done || !hs) begin
      tests++; fails++;
      $display("FAIL write_timeout addr=%h aw=%0d w=%0d b=%0d", a, aw_done, w_done, hs);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, input bit collide);
    int n;
    bit hs, ok_ar;
    d = '0; resp = 2'b11;
    axi.araddr = a; axi.arvalid = 1'b1; n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi.arready;
      step();
      n++;
    end
    ok_ar = hs;
    axi.arvalid = 1'b0; axi.rready = 1'b1; n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi.rvalid;
      if (hs) begin
        d = axi.rdata; resp = axi.rresp;
        if (collide) irq_src[0] = 1'b1;
      end
      step();
      n++;
    end
    axi.rready = 1'b0;
    if (collide) irq_src[0] = 1'b0;
    if (!ok_ar || !hs) begin
      tests++; fails++;
      $display("FAIL read_timeout addr=%h ar=%0d r=%0d", a, ok_ar, hs);
    end
  endtask

  task automatic pulse(input logic [2:0] m);
    irq_src = m;
    step();
    irq_src = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] addrs [4];
    addrs[0] = A_PEND; addrs[1] = A_EN; addrs[2] = A_CLAIM; addrs[3] = A_TRIG;
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests++;
    if ({irq, axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=000000",
               {irq, axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    tests++;
    if ({axi.bresp, axi.rresp} !== 4'b0) begin
      fails++; $display("FAIL reset_resp got=%b want=0000", {axi.bresp, axi.rresp});
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], d, r, 0);
      tests++;
      if (d !== 32'h0 || r !== 2'b00) begin
        fails++; $display("FAIL reset_reg%0d got=%h/%b want=0/00", i, d, r);
      end
    end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b want=0", irq); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(A_EN, 32'h7, 4'hF, r);
    axi_write(A_TRIG, 32'h1, 4'hF, r);
    irq_src[0] = 1'b1;
    step();
    irq_src[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_early got=%b want=0", irq); end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL edge_irq_rise got=%b want=1", irq); end
    step();
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL edge_pending got=%h want=1", d); end
    axi_read(A_CLAIM, d, r, 0);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL edge_claim got=%h want=1", d); end
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL edge_pending_cleared got=%h want=0", d); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_fall got=%b want=0", irq); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(A_TRIG, 32'h0, 4'hF, r);
    axi_write(A_EN, 32'h4, 4'hF, r);
    irq_src[2] = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      axi_read(A_CLAIM, d, r, 0);
      tests++;
      if (d !== 32'h3) begin fails++; $display("FAIL level_claim%0d got=%h want=3", i, d); end
    end
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL level_irq_held got=%b want=1", irq); end
    irq_src[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL level_irq_lag got=%b want=1", irq); end
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL level_irq_drop got=%b want=0", irq); end
    step();
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp [3];
    exp[0] = 32'h2; exp[1] = 32'h3; exp[2] = 32'h0;
    axi_write(A_TRIG, 32'h7, 4'hF, r);
    axi_write(A_EN, 32'h7, 4'hF, r);
    pulse(3'b110);
    step();
    for (int i = 0; i < 3; i++) begin
      axi_read(A_CLAIM, d, r, 0);
      tests++;
      if (d !== exp[i]) begin fails++; $display("FAIL prio_claim%0d got=%h want=%h", i, d, exp[i]); end
    end
  endtask

  task automatic test_claim_collision();
    logic [31:0] d;
    logic [1:0]  r;
    pulse(3'b001);
    step();
    axi_read(A_CLAIM, d, r, 1);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL coll_claim got=%h want=1", d); end
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL coll_pending_kept got=%h want=1", d); end
    axi_read(A_CLAIM, d, r, 0);
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL coll_pending_after got=%h want=0", d); end
  endtask

  task automatic test_disabled_latch();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(A_EN, 32'h0, 4'hF, r);
    pulse(3'b001);
    repeat (3) step();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL dis_irq got=%b want=0", irq); end
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL dis_pending got=%h want=1", d); end
    axi_read(A_CLAIM, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL dis_claim got=%h want=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(A_EN, 32'h0000_00FF, 4'b1110, r);
    axi_read(A_EN, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL strb_masked got=%h want=0", d); end
    axi_write(A_EN, 32'hFFFF_FF03, 4'b0001, r);
    axi_read(A_EN, d, r, 0);
    tests++;
    if (d !== 32'h3) begin fails++; $display("FAIL strb_byte0 got=%h want=3", d); end
    axi_write(32'h0000_0014, 32'h6, 4'hF, r);
    axi_read(32'h0000_0037, d, r, 0);
    tests++;
    if (d !== 32'h6) begin fails++; $display("FAIL alias_enable got=%h want=6", d); end
    axi_write(A_PEND, 32'h0, 4'hF, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL ro_pend_bresp got=%b want=00", r); end
    axi_write(A_CLAIM, 32'hFFFF_FFFF, 4'hF, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL ro_claim_bresp got=%b want=00", r); end
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL ro_pending_kept got=%h want=1", d); end
    axi_write(A_TRIG, 32'hFFFF_FFF8, 4'hF, r);
    axi_read(A_TRIG, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL trig_upper_bits got=%h want=0", d); end
    axi_read(A_PEND, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL edge_to_level got=%h want=0", d); end
    axi_write(A_TRIG, 32'hFFFF_FFFF, 4'hF, r);
    axi_read(A_TRIG, d, r, 0);
    tests++;
    if (d !== 32'h7) begin fails++; $display("FAIL trig_all got=%h want=7", d); end
  endtask

  task automatic test_write_fsm();
    logic [31:0] d;
    logic [1:0]  r;
    int aw_cnt, b_cnt;
    bit hs;
    aw_cnt = 0; b_cnt = 0;
    axi.awaddr = A_EN; axi.awvalid = 1'b1; axi.wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hs = axi.awvalid && axi.awready;
      if (hs) aw_cnt++;
      if (c > 0) begin
        tests++;
        if (axi.awready !== 1'b0) begin fails++; $display("FAIL wfsm_aw_once c%0d got=%b want=0", c, axi.awready); end
      end
      step();
      if (hs) axi.awvalid = 1'b0;
    end
    axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    tests++;
    if (axi.wready !== 1'b1) begin fails++; $display("FAIL wfsm_wready got=%b want=1", axi.wready); end
    step();
    axi.wvalid = 1'b0;
    axi.awaddr = A_TRIG; axi.awvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (axi.awvalid && axi.awready) aw_cnt++;
      tests++;
      if (axi.bvalid !== 1'b1 || axi.awready !== 1'b0) begin
        fails++; $display("FAIL wfsm_resp_hold c%0d bvalid=%b awready=%b want=1/0", c, axi.bvalid, axi.awready);
      end
      step();
    end
    axi.awvalid = 1'b0; axi.bready = 1'b1;
    @(negedge clk);
    if (axi.bvalid) b_cnt++;
    step();
    axi.bready = 1'b1;
    @(negedge clk);
    if (axi.bvalid) b_cnt++;
    step();
    axi.bready = 1'b0;
    tests++;
    if (aw_cnt != 1 || b_cnt != 1) begin
      fails++; $display("FAIL wfsm_counts aw=%0d b=%0d want=1/1", aw_cnt, b_cnt);
    end
    axi_read(A_EN, d, r, 0);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL wfsm_enable got=%h want=5", d); end
    axi_read(A_TRIG, d, r, 0);
    tests++;
    if (d !== 32'h7) begin fails++; $display("FAIL wfsm_no_extra_write got=%h want=7", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    axi.araddr = A_EN; axi.arvalid = 1'b1;
    @(negedge clk);
    step();
    axi.arvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (axi.rvalid !== 1'b1) begin fails++; $display("FAIL mid_rvalid_before got=%b want=1", axi.rvalid); end
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if ({axi.rvalid, axi.arready, axi.bvalid, irq} !== 4'b0) begin
      fails++; $display("FAIL mid_reset_outputs got=%b want=0000", {axi.rvalid, axi.arready, axi.bvalid, irq});
    end
    step();
    rst_n = 1'b1;
    step();
    axi_read(A_EN, d, r, 0);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL mid_enable_cleared got=%h want=0", d); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; irq_src = '0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    #1;
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_claim_collision();
    test_disabled_latch();
    test_regs();
    test_write_fsm();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
